// File: rtl/wb_bram_port.sv
// Wishbone pipelined slave in front of a 512x64 byte-writable synchronous RAM.
// An optional zero-fill pass runs after reset before the bus is served.
module wb_bram_port #(
  parameter int ADR_BITS = 29,
  parameter bit SCRUB    = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [7:0]          wb_sel,
  input  logic [ADR_BITS-1:0] wb_adr,
  input  logic [63:0]         wb_dat_w,
  output logic [63:0]         wb_dat_r,
  output logic                wb_ack,
  output logic                wb_stall,
  output logic                ram_en,
  output logic [7:0]          ram_we,
  output logic [8:0]          ram_a,
  output logic [63:0]         ram_di,
  input  logic [63:0]         ram_do,
  output logic                init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [8:0] cnt_reg, cnt_next;
  logic       ack_reg, ack_next;
  logic       init_done_reg, init_done_next;
  logic       accept;

  // Address bits above the RAM depth alias onto the same 512 words.
  generate
    if (ADR_BITS > 9) begin : g_adr_hi
      logic unused_adr_hi;
      assign unused_adr_hi = ^wb_adr[ADR_BITS-1:9];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg     <= SCRUB ? ST_INIT : ST_RUN;
      cnt_reg       <= 9'd0;
      ack_reg       <= 1'b0;
      init_done_reg <= !SCRUB;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ack_reg       <= ack_next;
      init_done_reg <= init_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ack_next       = 1'b0;
    init_done_next = init_done_reg;
    accept         = 1'b0;
    ram_en         = 1'b0;
    ram_we         = 8'h00;
    ram_a          = cnt_reg;
    ram_di         = 64'd0;
    wb_stall       = 1'b1;
    case (state_reg)
      ST_INIT: begin
        ram_en = 1'b1;
        ram_we = 8'hFF;
        // Counter parks on 511; the last write hands over to RUN.
        if (cnt_reg == 9'd511) begin
          state_next     = ST_RUN;
          init_done_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 9'd1;
        end
      end
      ST_RUN: begin
        wb_stall = 1'b0;
        accept   = wb_cyc & wb_stb;
        ram_en   = accept;
        ram_a    = wb_adr[8:0];
        ram_di   = wb_dat_w;
        ram_we   = (accept & wb_we) ? wb_sel : 8'h00;
        ack_next = accept;
      end
      default: state_next = ST_RUN;
    endcase
    // Nothing reaches the RAM or the bus while reset is held.
    if (!RST_N) begin
      ram_en   = 1'b0;
      ram_we   = 8'h00;
      wb_stall = 1'b1;
    end
  end

  assign wb_ack    = ack_reg & wb_cyc & RST_N;
  assign wb_dat_r  = ram_do;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_wb_bram_port.sv
// Directed bench for wb_bram_port: one scrubbing instance and one non-scrubbing
// instance share the bus inputs, each backed by its own behavioural RAM.
module tb_wb_bram_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        preload;
  logic        cyc, stb, we;
  logic [7:0]  sel;
  logic [28:0] adr;
  logic [63:0] dat_w;

  logic [63:0] dat_r1, dat_r0;
  logic        ack1, ack0, stall1, stall0, en1, en0, done1, done0;
  logic [7:0]  rwe1, rwe0;
  logic [8:0]  ra1, ra0;
  logic [63:0] rdi1, rdi0, rdo1, rdo0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_bram_port #(.ADR_BITS(29), .SCRUB(1'b1)) dut (
    .CLK(clk), .RST_N(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_sel(sel), .wb_adr(adr), .wb_dat_w(dat_w), .wb_dat_r(dat_r1),
    .wb_ack(ack1), .wb_stall(stall1), .ram_en(en1), .ram_we(rwe1),
    .ram_a(ra1), .ram_di(rdi1), .ram_do(rdo1), .init_done(done1)
  );

  wb_bram_port #(.ADR_BITS(29), .SCRUB(1'b0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
    .wb_sel(sel), .wb_adr(adr), .wb_dat_w(dat_w), .wb_dat_r(dat_r0),
    .wb_ack(ack0), .wb_stall(stall0), .ram_en(en0), .ram_we(rwe0),
    .ram_a(ra0), .ram_di(rdi0), .ram_do(rdo0), .init_done(done0)
  );

  function automatic logic [63:0] pat(int i);
    return 64'hA5A5_A5A5_A5A5_A5A5 ^ 64'(i);
  endfunction

  logic [63:0] mem1 [512];
  logic [63:0] mem0 [512];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem1[i] <= pat(i);
    end else if (en1) begin
      for (int b = 0; b < 8; b++)
        if (rwe1[b]) mem1[ra1][8*b +: 8] <= rdi1[8*b +: 8];
      rdo1 <= mem1[ra1];
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem0[i] <= pat(i);
    end else if (en0) begin
      for (int b = 0; b < 8; b++)
        if (rwe0[b]) mem0[ra0][8*b +: 8] <= rdi0[8*b +: 8];
      rdo0 <= mem0[ra0];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [7:0] s, input logic [28:0] a, input logic [63:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_w = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (ack1 !== 1'b0)   begin errors++; $display("FAIL reset_ack got=%b exp=0", ack1); end
    checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL reset_stall got=%b exp=1", stall1); end
    checks++; if (en1 !== 1'b0)    begin errors++; $display("FAIL reset_ram_en got=%b exp=0", en1); end
    checks++; if (rwe1 !== 8'h00)  begin errors++; $display("FAIL reset_ram_we got=%h exp=00", rwe1); end
    checks++; if (done1 !== 1'b0)  begin errors++; $display("FAIL reset_init_done got=%b exp=0", done1); end
    checks++; if (done0 !== 1'b1)  begin errors++; $display("FAIL reset_init_done0 got=%b exp=1", done0); end
    $display("reset: ack=%b stall=%b ram_en=%b init_done=%b/%b", ack1, stall1, en1, done1, done0);
  endtask

  // Entered just after reset release; walks all 512 scrub cycles.
  task automatic test_scrub(input string tag);
    int bad = 0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      if (stall1 !== 1'b1 || en1 !== 1'b1 || rwe1 !== 8'hFF || rdi1 !== 64'd0 ||
          ra1 !== 9'(k) || ack1 !== 1'b0 || done1 !== 1'b0) begin
        bad++;
        if (bad <= 4)
          $display("FAIL %s_cycle%0d got stall=%b en=%b we=%h di=%h a=%0d done=%b exp stall=1 en=1 we=ff di=0 a=%0d done=0",
                   tag, k, stall1, en1, rwe1, rdi1, ra1, done1, k);
      end
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL %s_seq bad_cycles=%0d exp=0", tag, bad); end
    @(negedge clk);
    checks++; if (done1 !== 1'b1)  begin errors++; $display("FAIL %s_done got=%b exp=1", tag, done1); end
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL %s_stall_end got=%b exp=0", tag, stall1); end
    $display("%s: 512 scrub cycles, bad=%0d init_done=%b stall=%b", tag, bad, done1, stall1);
    step();
  endtask

  task automatic test_read_scrubbed();
    req(1'b0, 8'h00, 29'h1FF, 64'd0);
    @(negedge clk);
    checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL rd1ff_stall got=%b exp=0", stall1); end
    step(); stb = 1'b0;
    @(negedge clk);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL rd1ff_ack got=%b exp=1", ack1); end
    checks++; if (dat_r1 !== 64'd0) begin errors++; $display("FAIL rd1ff_data got=%h exp=0", dat_r1); end
    $display("read 0x1ff: ack=%b data=%h", ack1, dat_r1);
    step(); cyc = 1'b0;
  endtask

  task automatic test_byte_write();
    req(1'b1, 8'hFF, 29'h010, 64'h1122_3344_5566_7788);
    step(); stb = 1'b0;
    @(negedge clk);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL bw_ack1 got=%b exp=1", ack1); end
    step(); req(1'b1, 8'h0F, 29'h010, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL bw_ack_gap got=%b exp=0", ack1); end
    step(); stb = 1'b0;
    @(negedge clk);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL bw_ack2 got=%b exp=1", ack1); end
    step(); req(1'b0, 8'h00, 29'h010, 64'd0);
    step(); stb = 1'b0;
    @(negedge clk);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL bw_ack3 got=%b exp=1", ack1); end
    checks++; if (dat_r1 !== 64'h1122_3344_FFFF_FFFF) begin
      errors++; $display("FAIL bw_data got=%h exp=11223344ffffffff", dat_r1);
    end
    $display("byte write 0x010: read back %h", dat_r1);
    step(); cyc = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Load 0..3, then stream four reads; one ack per cycle from cycle 1 on.
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 8'hFF, 29'(i), 64'(i));
      if (i > 0) begin
        @(negedge clk);
        checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL b2b_wack%0d got=%b exp=1", i, ack1); end
      end
      step();
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 4) req(1'b0, 8'h00, 29'(i), 64'd0);
      else stb = 1'b0;
      @(negedge clk);
      checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d got=%b exp=0", i, stall1); end
      checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d got=%b exp=1", i, ack1); end
      if (i > 0) begin
        checks++; if (dat_r1 !== 64'(i - 1)) begin
          errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i - 1, dat_r1, 64'(i - 1));
        end
        $display("b2b read %0d: ack=%b data=%h", i - 1, ack1, dat_r1);
      end
      step();
    end
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL b2b_ack_end got=%b exp=0", ack1); end
    cyc = 1'b0;
    step();
  endtask

  task automatic test_abort();
    req(1'b1, 8'hFF, 29'h005, 64'h55);
    step();
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 29'h006; dat_w = 64'hDEAD;
    @(negedge clk);
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL abort_ack got=%b exp=0", ack1); end
    checks++; if (en1 !== 1'b0)  begin errors++; $display("FAIL abort_ram_en got=%b exp=0", en1); end
    $display("abort: ack=%b ram_en=%b", ack1, en1);
    step(); stb = 1'b0;
    step(); req(1'b0, 8'h00, 29'h005, 64'd0);
    step(); stb = 1'b0;
    @(negedge clk);
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL abort_rd_ack got=%b exp=1", ack1); end
    checks++; if (dat_r1 !== 64'h55) begin errors++; $display("FAIL abort_rd_data got=%h exp=55", dat_r1); end
    $display("read 0x005 after abort: %h", dat_r1);
    step(); cyc = 1'b0;
  endtask

  task automatic test_mid_scrub_reset();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int k = 0; k < 200; k++) step();
    @(negedge clk);
    checks++; if (ra1 !== 9'd200) begin errors++; $display("FAIL midrst_pre_a got=%0d exp=200", ra1); end
    rst_n = 1'b0;
    #1;
    checks++; if (en1 !== 1'b0)    begin errors++; $display("FAIL midrst_ram_en got=%b exp=0", en1); end
    checks++; if (stall1 !== 1'b1) begin errors++; $display("FAIL midrst_stall got=%b exp=1", stall1); end
    $display("reset at scrub 200: ram_en=%b stall=%b", en1, stall1);
    step(); rst_n = 1'b1;
    test_scrub("rescrub");
  endtask

  task automatic test_noscrub();
    rst_n = 1'b0; preload = 1'b1;
    step(); step();
    rst_n = 1'b1; preload = 1'b0;
    req(1'b0, 8'h00, 29'h200, 64'd0);
    @(negedge clk);
    checks++; if (done0 !== 1'b1)  begin errors++; $display("FAIL ns_done got=%b exp=1", done0); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL ns_stall got=%b exp=0", stall0); end
    checks++; if (en0 !== 1'b1 || ra0 !== 9'd0) begin
      errors++; $display("FAIL ns_ram got en=%b a=%0d exp en=1 a=0", en0, ra0);
    end
    step(); stb = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL ns_ack got=%b exp=1", ack0); end
    checks++; if (dat_r0 !== pat(0)) begin errors++; $display("FAIL ns_data got=%h exp=%h", dat_r0, pat(0)); end
    $display("no-scrub read 0x200: ack=%b data=%h", ack0, dat_r0);
    step(); req(1'b0, 8'h00, 29'h001, 64'd0);
    step(); rst_n = 1'b0; stb = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL ns_rst_ack got=%b exp=0", ack0); end
    step(); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL ns_post_rst_ack got=%b exp=0", ack0); end
    $display("reset mid-transfer: ack=%b", ack0);
    cyc = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 8'h00; adr = '0; dat_w = '0;
    repeat (3) step();
    test_reset();
    step();
    rst_n = 1'b1; preload = 1'b0;
    test_scrub("scrub");
    test_read_scrubbed();
    test_byte_write();
    test_back_to_back();
    test_abort();
    test_mid_scrub_reset();
    test_noscrub();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
